mult_div_unit: RTL and testbench

//   Multicycle signed MULT/DIV datapath unit for the MIPS multicycle CPU. Sits downstream
//   of the control unit: started by the controller from the MULT/DIV execute states,

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit: radix-2 Booth multiply and restoring divide,
// one step per clock, with results committed to hi/lo in a single FINISH cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        FINISH   = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            is_div;

    // Booth registers; acc carries one guard bit so subtracting the most negative multiplicand cannot wrap
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic             mq_1;
    logic [WIDTH-1:0] mcand;

    // Divide registers operate on magnitudes
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   mcand_x;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic             unused_diff_msb;

    // One Booth add/subtract step ahead of the arithmetic shift
    always_comb begin
        mcand_x = {mcand[WIDTH-1], mcand};
        acc_sum = acc;
        case ({mq[0], mq_1})
            2'b01:   acc_sum = acc + mcand_x;
            2'b10:   acc_sum = acc - mcand_x;
            default: acc_sum = acc;
        endcase
    end

    // One restoring-division trial subtraction
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, dvs};
        ge       = ~diff[WIDTH+1];
        rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    // A successful trial always leaves a remainder below the divisor, so this bit is always zero
    assign unused_diff_msb = diff[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            mq_1     <= 1'b0;
            mcand    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        mcand  <= op_a;
                        acc    <= '0;
                        mq     <= op_b;
                        mq_1   <= 1'b0;
                        count  <= '0;
                        is_div <= 1'b0;
                        busy   <= 1'b1;
                        state  <= MULT_RUN;
                    end else if (start_div) begin
                        if (op_b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            rem    <= '0;
                            quo    <= op_a[WIDTH-1] ? -op_a : op_a;
                            dvs    <= op_b[WIDTH-1] ? -op_b : op_b;
                            neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r  <= op_a[WIDTH-1];
                            count  <= '0;
                            is_div <= 1'b1;
                            busy   <= 1'b1;
                            state  <= DIV_RUN;
                        end
                    end
                end
                MULT_RUN: begin
                    acc   <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
                    mq    <= {acc_sum[0], mq[WIDTH-1:1]};
                    mq_1  <= mq[0];
                    count <= count + CW'(1);
                    if (count == LAST_STEP) state <= FINISH;
                end
                DIV_RUN: begin
                    rem   <= rem_next;
                    quo   <= {quo[WIDTH-2:0], ge};
                    count <= count + CW'(1);
                    if (count == LAST_STEP) state <= FINISH;
                end
                FINISH: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign
                    if (is_div) begin
                        hi <= neg_r ? -rem : rem;
                        lo <= neg_q ? -quo : quo;
                    end else begin
                        hi <= acc[WIDTH-1:0];
                        lo <= mq;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results from a
// plain-arithmetic model; a negedge monitor pops and compares on done/div_zero.
module tb_mult_div_unit;
    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        bit        dz;
        bit [31:0] hi;
        bit [31:0] lo;
    } exp_t;

    exp_t      sbq[$];
    bit [31:0] cur_hi = '0;
    bit [31:0] cur_lo = '0;
    int        checks = 0;
    int        errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full 64-bit signed product, or signed quotient/remainder via 64-bit arithmetic
    function automatic exp_t model(input bit is_div, input bit [31:0] a, input bit [31:0] b);
        exp_t   e;
        longint x;
        longint y;
        longint p;
        longint q;
        longint r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        if (!is_div) begin
            p    = x * y;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.dz = 1'b1;
        end else begin
            q    = x / y;
            r    = x % y;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Monitor: compare on result pulses, otherwise hi/lo must hold the last committed value
    always @(negedge clk) begin
        exp_t e;
        chk("done_and_dz_exclusive", 64'(done & div_zero), 64'd0);
        if (done || div_zero) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result_pulse", {62'd0, done, div_zero}, 64'd0);
            end else begin
                e = sbq.pop_front();
                if (e.dz) begin
                    chk("dz_flag", 64'(div_zero), 64'd1);
                    chk("dz_hi_unchanged", 64'(hi), 64'(cur_hi));
                    chk("dz_lo_unchanged", 64'(lo), 64'(cur_lo));
                end else begin
                    chk("done_flag", 64'(done), 64'd1);
                    chk("result_hi", 64'(hi), 64'(e.hi));
                    chk("result_lo", 64'(lo), 64'(e.lo));
                    cur_hi = e.hi;
                    cur_lo = e.lo;
                end
            end
        end else begin
            chk("hold_hi", 64'(hi), 64'(cur_hi));
            chk("hold_lo", 64'(lo), 64'(cur_lo));
        end
    end

    // Issue one request, then track latency/busy while poking ignored starts and operands
    task automatic run_op(input bit sm, input bit sd, input bit [31:0] a, input bit [31:0] b);
        int n;
        int bc;
        bit dz_case;
        dz_case = !sm && sd && (b == 32'd0);
        sbq.push_back(model(!sm, a, b));
        start_mult = sm;
        start_div  = sd;
        op_a       = a;
        op_b       = b;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        if (dz_case) begin
            chk("dz_busy_low", 64'(busy), 64'd0);
            chk("dz_done_low", 64'(done), 64'd0);
        end else begin
            chk("busy_after_accept", 64'(busy), 64'd1);
            bc = busy ? 1 : 0;
            n  = 0;
            while (!done && n < 40) begin
                if ($urandom_range(0, 3) == 0) begin
                    start_mult = 1'($urandom_range(0, 1));
                    start_div  = 1'($urandom_range(0, 1));
                    op_a       = $urandom;
                    op_b       = $urandom_range(0, 1) == 0 ? 32'd0 : $urandom;
                end
                @(posedge clk);
                #1;
                n++;
                if (!done && busy) bc++;
            end
            start_mult = 1'b0;
            start_div  = 1'b0;
            chk("done_latency", 64'(n), 64'd33);
            chk("busy_cycles", 64'(bc), 64'd33);
            chk("busy_low_at_done", 64'(busy), 64'd0);
        end
    endtask

    function automatic bit [31:0] pick_operand();
        bit [31:0] specials[5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 4) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 2) == 0) return 32'($signed($urandom_range(0, 200)) - 100);
        return $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(div_zero), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
        chk("t1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t1_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        chk("t2_hi", 64'(hi), 64'h4000_0000);
        chk("t2_lo", 64'(lo), 64'h0000_0000);
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("t3a_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t3a_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op(1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        chk("t3b_hi", 64'(hi), 64'h0000_0001);
        chk("t3b_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t4_hi", 64'(hi), 64'h0000_0000);
        chk("t4_lo", 64'(lo), 64'h8000_0000);
        run_op(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000);
        chk("t5_hi_kept", 64'(hi), 64'h0000_0000);
        chk("t5_lo_kept", 64'(lo), 64'h8000_0000);
        run_op(1'b1, 1'b1, 32'h0000_0006, 32'h0000_0000);

        // Abort a multiply with reset after a mid-run divide request
        sbq.push_back(model(1'b0, 32'h1234_5678, 32'h9ABC_DEF0));
        start_mult = 1'b1;
        op_a       = 32'h1234_5678;
        op_b       = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start_div = 1'b1;
        op_a      = 32'h0000_0064;
        op_b      = 32'h0000_0003;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_busy_mid", 64'(busy), 64'd1);
        reset = 1'b0;
        sbq.delete();
        cur_hi = '0;
        cur_lo = '0;
        #1;
        chk("t6_busy_reset", 64'(busy), 64'd0);
        chk("t6_done_reset", 64'(done), 64'd0);
        chk("t6_hi_reset", 64'(hi), 64'd0);
        chk("t6_lo_reset", 64'(lo), 64'd0);
        start_div = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(1'b1, 1'b0, 32'd3, 32'd4);
        chk("t6_next_lo", 64'(lo), 64'd12);
        chk("t6_next_hi", 64'(hi), 64'd0);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4)      run_op(1'b1, 1'b0, pick_operand(), pick_operand());
            else if (k < 8) run_op(1'b0, 1'b1, pick_operand(), pick_operand());
            else if (k == 8) run_op(1'b0, 1'b1, pick_operand(), 32'd0);
            else            run_op(1'b1, 1'b1, pick_operand(), pick_operand());
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
